dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Sequencing controller and two-port arbiter in front of the byte-addressed data memory (32-bit word read/write, combinational read, synchronous write).
- Shares the memory between port A (core load/store path) and port B (debug/DMA).
- Converts byte/half stores into read-modify-write sequences, because the memory writes only full words.
- Sign- or zero-extends byte/half loads.

Parameters:
WORD_SIZE, 32, data and address width; equals `WORD_SIZE.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_a_req  input  1  port A request; held with its fields until o_a_ack
i_a_we  input  1  port A: 1 = store, 0 = load
i_a_size  input  2  port A: 00 byte, 01 half, 10 word; 11 treated as word
i_a_uns  input  1  port A: load zero-extends when 1
i_a_addr  input  WORD_SIZE  port A byte address
i_a_wd  input  WORD_SIZE  port A store data (low bytes used for sub-word)
o_a_ack  output  1  port A completion pulse, 1 cycle
o_a_rd  output  WORD_SIZE  port A load data, valid while o_a_ack
i_b_req, i_b_we, i_b_size, i_b_uns, i_b_addr, i_b_wd, o_b_ack, o_b_rd  same as port A, for port B
o_err  output  1  misalignment pulse (optional feature only; tied 0 otherwise)
o_mem_addr  output  WORD_SIZE  memory address
o_mem_wd  output  WORD_SIZE  memory write data
o_mem_wen  output  1  memory write enable
o_mem_ren  output  1  memory read enable
i_mem_rd  input  WORD_SIZE  memory read data (combinational from o_mem_addr)

Behaviour:
- Reset (synchronous, i_rst=1 at a posedge): state IDLE, last_grant=B. All outputs 0 from the next cycle.
- Reset mid-sequence aborts the sequence. No o_mem_wen is issued in or after the reset cycle. No ack for the aborted request.
- Grant in IDLE:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not equal to last_grant is granted (round-robin), and last_grant updates.
  - The granted request's fields are latched into internal regs at the grant edge. Later changes on the inputs are ignored until ack.
- States:
  - IDLE: no request -> IDLE. Load or word store -> ACCESS. Byte/half store -> RMW_RD.
  - ACCESS:
    - Load: o_mem_addr=addr, o_mem_ren=1; i_mem_rd is captured.
    - Word store: o_mem_addr=addr, o_mem_wd=wd, o_mem_wen=1.
    - Next state: RESP.
  - RMW_RD: o_mem_ren=1 at addr; capture i_mem_rd as old. Next state: RMW_WR.
  - RMW_WR: o_mem_wen=1 at addr.
    - Byte: o_mem_wd={old[31:8], wd[7:0]}.
    - Half: o_mem_wd={old[31:16], wd[15:0]}.
    - Next state: RESP.
  - RESP: granted port's o_x_ack=1 for exactly one cycle. Next state: IDLE.
- Load data presented in RESP:
  - Byte: {24{~uns & d[7]}, d[7:0]}.
  - Half: {16{~uns & d[15]}, d[15:0]}.
  - Word: d.
- o_x_rd holds its value after ack until the next load ack on that port. It is 0 after reset.
- Latency from grant edge to ack: load or word store = 2 cycles; byte/half store = 3 cycles.
- A requester may keep req high after ack to issue a new request. That request is arbitrated in the IDLE cycle that follows RESP.
- The non-granted port waits; its request is never dropped.
- Memory enables are mutually exclusive; o_mem_wen and o_mem_ren are never high together. Both are 0 in IDLE and RESP.
- Address arithmetic: the address is passed through unchanged. No wrap handling; the memory is responsible for its own range.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined: a misaligned request skips all memory states and goes IDLE -> RESP.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - In RESP: o_err=1 together with the ack; o_x_rd is unchanged; no o_mem_ren or o_mem_wen occurs.
- Undefined: no check is made; o_err is constant 0; misaligned accesses proceed normally.

Test Plan:
- Word store then load: A stores 0xDEADBEEF at 0x10; A loads word at 0x10 -> o_a_rd=0xDEADBEEF. Ack is 2 cycles after each grant.
- Byte store RMW: memory 0x11223344 at 0x20; A stores byte 0xAA at 0x20 -> memory word 0x112233AA. Ack on cycle 3 after grant; exactly one ren cycle then one wen cycle.
- Sign/zero extension: memory byte 0x80 at 0x30. LB -> 0xFFFFFF80; LBU -> 0x00000080. Half 0x8001: LH -> 0xFFFF8001; LHU -> 0x00008001.
- Arbitration: A and B both request continuously from reset. Grants go A, B, A, B. Each port receives its own ack and data; the idle port's ack stays 0.
- Reset mid-RMW: assert i_rst in the RMW_RD cycle -> no o_mem_wen, no ack, and memory is unchanged. The controller is in IDLE with outputs 0 after reset.
- With DMEM_ALIGN_CHECK_EN: word load at 0x22 -> ack and o_err one cycle after grant, no mem enables. Without the macro, the same load returns the bytes at 0x22..0x25 and o_err stays 0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory sequencer: round-robin arbiter for ports A/B, RMW for sub-word stores, load extension.
// Optional misalignment check enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_ctrl #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_a_req,
  input  logic                 i_a_we,
  input  logic [1:0]           i_a_size,
  input  logic                 i_a_uns,
  input  logic [WORD_SIZE-1:0] i_a_addr,
  input  logic [WORD_SIZE-1:0] i_a_wd,
  output logic                 o_a_ack,
  output logic [WORD_SIZE-1:0] o_a_rd,
  input  logic                 i_b_req,
  input  logic                 i_b_we,
  input  logic [1:0]           i_b_size,
  input  logic                 i_b_uns,
  input  logic [WORD_SIZE-1:0] i_b_addr,
  input  logic [WORD_SIZE-1:0] i_b_wd,
  output logic                 o_b_ack,
  output logic [WORD_SIZE-1:0] o_b_rd,
  output logic                 o_err,
  output logic [WORD_SIZE-1:0] o_mem_addr,
  output logic [WORD_SIZE-1:0] o_mem_wd,
  output logic                 o_mem_wen,
  output logic                 o_mem_ren,
  input  logic [WORD_SIZE-1:0] i_mem_rd
);

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RMW_RD, S_RMW_WR, S_RESP} state_e;

  state_e               state_q, state_d;
  logic                 last_q, last_d;   // 0 = A, 1 = B
  logic                 gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wd_q, wd_d;
  logic [WORD_SIZE-1:0] old_q, old_d;
  logic                 err_q, err_d;
  logic [WORD_SIZE-1:0] a_rd_q, a_rd_d;
  logic [WORD_SIZE-1:0] b_rd_q, b_rd_d;

  logic                 pick_b;
  logic                 sel_we, sel_uns, mis;
  logic [1:0]           sel_size;
  logic [WORD_SIZE-1:0] sel_addr, sel_wd, load_val;
  logic                 wen_c;

  function automatic logic [WORD_SIZE-1:0] extend(input logic [WORD_SIZE-1:0] d,
                                                  input logic [1:0] sz, input logic uns);
    case (sz)
      2'b00:   extend = {{(WORD_SIZE-8){~uns & d[7]}}, d[7:0]};
      2'b01:   extend = {{(WORD_SIZE-16){~uns & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // Both requesting: grant the port that did not win last time.
  assign pick_b   = i_b_req & (~i_a_req | ~last_q);
  assign sel_we   = pick_b ? i_b_we   : i_a_we;
  assign sel_size = pick_b ? i_b_size : i_a_size;
  assign sel_uns  = pick_b ? i_b_uns  : i_a_uns;
  assign sel_addr = pick_b ? i_b_addr : i_a_addr;
  assign sel_wd   = pick_b ? i_b_wd   : i_a_wd;
  assign load_val = extend(i_mem_rd, size_q, uns_q);

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = ((sel_size == 2'b01) & sel_addr[0]) | (sel_size[1] & (sel_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    old_d      = old_q;
    err_d      = err_q;
    a_rd_d     = a_rd_q;
    b_rd_d     = b_rd_q;
    o_mem_addr = '0;
    o_mem_wd   = '0;
    o_mem_ren  = 1'b0;
    wen_c      = 1'b0;
    o_a_ack    = 1'b0;
    o_b_ack    = 1'b0;
    o_err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_a_req | i_b_req) begin
          gnt_d  = pick_b;
          last_d = pick_b;
          we_d   = sel_we;
          size_d = sel_size;
          uns_d  = sel_uns;
          addr_d = sel_addr;
          wd_d   = sel_wd;
          err_d  = mis;
          if (mis)                          state_d = S_RESP;
          else if (sel_we & ~sel_size[1])   state_d = S_RMW_RD;
          else                              state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        o_mem_addr = addr_q;
        if (we_q) begin
          o_mem_wd = wd_q;
          wen_c    = 1'b1;
        end else begin
          o_mem_ren = 1'b1;
          if (gnt_q) b_rd_d = load_val;
          else       a_rd_d = load_val;
        end
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        o_mem_addr = addr_q;
        o_mem_ren  = 1'b1;
        old_d      = i_mem_rd;
        state_d    = S_RMW_WR;
      end
      S_RMW_WR: begin
        o_mem_addr = addr_q;
        wen_c      = 1'b1;
        o_mem_wd   = (size_q == 2'b00) ? {old_q[WORD_SIZE-1:8], wd_q[7:0]}
                                       : {old_q[WORD_SIZE-1:16], wd_q[15:0]};
        state_d    = S_RESP;
      end
      S_RESP: begin
        o_a_ack = ~gnt_q;
        o_b_ack = gnt_q;
        o_err   = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A reset arriving while a write is pending must not let it reach memory.
  assign o_mem_wen = wen_c & ~i_rst;
  assign o_a_rd    = a_rd_q;
  assign o_b_rd    = b_rd_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      old_q   <= '0;
      err_q   <= 1'b0;
      a_rd_q  <= '0;
      b_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      old_q   <= old_d;
      err_q   <= err_d;
      a_rd_q  <= a_rd_d;
      b_rd_q  <= b_rd_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a little-endian byte-array memory model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, a_uns, b_req, b_we, b_uns;
  logic [1:0]  a_size, b_size;
  logic [31:0] a_addr, a_wd, b_addr, b_wd;
  logic        a_ack, b_ack, err, mem_wen, mem_ren;
  logic [31:0] a_rd, b_rd, mem_addr, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_ctrl #(.WORD_SIZE(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_size(a_size), .i_a_uns(a_uns),
    .i_a_addr(a_addr), .i_a_wd(a_wd), .o_a_ack(a_ack), .o_a_rd(a_rd),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_size(b_size), .i_b_uns(b_uns),
    .i_b_addr(b_addr), .i_b_wd(b_wd), .o_b_ack(b_ack), .o_b_rd(b_rd),
    .o_err(err), .o_mem_addr(mem_addr), .o_mem_wd(mem_wd),
    .o_mem_wen(mem_wen), .o_mem_ren(mem_ren), .i_mem_rd(mem_rd)
  );

  logic [7:0] mem [0:255];
  logic [7:0] ma0, ma1, ma2, ma3;
  assign ma0 = mem_addr[7:0];
  assign ma1 = ma0 + 8'd1;
  assign ma2 = ma0 + 8'd2;
  assign ma3 = ma0 + 8'd3;
  assign mem_rd = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};

  always @(posedge clk) begin
    if (mem_wen) begin
      mem[ma0] <= mem_wd[7:0];
      mem[ma1] <= mem_wd[15:8];
      mem[ma2] <= mem_wd[23:16];
      mem[ma3] <= mem_wd[31:24];
    end
  end

  function automatic logic [31:0] mword(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    mword = {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  int ren_cnt = 0, wen_cnt = 0, aack_cnt = 0, back_cnt = 0, err_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (mem_ren) ren_cnt <= ren_cnt + 1;
    if (mem_wen) wen_cnt <= wen_cnt + 1;
    if (a_ack)   aack_cnt <= aack_cnt + 1;
    if (b_ack)   back_cnt <= back_cnt + 1;
    if (err)     err_cnt <= err_cnt + 1;
    if (mem_wen && mem_ren) both_cnt <= both_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns the number of negedges until the ack.
  task automatic xfer(input bit pb, input bit we, input logic [1:0] sz, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output int lat, output bit e);
    if (pb) begin
      b_we = we; b_size = sz; b_uns = uns; b_addr = addr; b_wd = wd; b_req = 1'b1;
    end else begin
      a_we = we; a_size = sz; a_uns = uns; a_addr = addr; a_wd = wd; a_req = 1'b1;
    end
    lat = 99; rd = '0; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (pb ? b_ack : a_ack) begin
        lat = i;
        rd  = pb ? b_rd : a_rd;
        e   = err;
        break;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  int          lat, r0, w0, k0;
  bit          e;
  logic [3:0]  ord;
  int          nack;
  logic [31:0] ard0, ard1, brd0, brd1;

  initial begin
    rst = 1'b1;
    a_req = 0; a_we = 0; a_size = 0; a_uns = 0; a_addr = 0; a_wd = 0;
    b_req = 0; b_we = 0; b_size = 0; b_uns = 0; b_addr = 0; b_wd = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_acks_en", {28'd0, a_ack, b_ack, mem_wen, mem_ren}, 32'd0);
    check_eq("rst_a_rd", a_rd, 32'd0);
    check_eq("rst_b_rd", b_rd, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);

    // word store then load
    xfer(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, lat, e);
    check_eq("sw_lat", lat, 2);
    check_eq("sw_mem", mword(8'h10), 32'hDEADBEEF);
    xfer(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, lat, e);
    check_eq("lw_lat", lat, 2);
    check_eq("lw_data", rd, 32'hDEADBEEF);
    xfer(0, 0, 2'b11, 0, 32'h10, 32'h0, rd, lat, e);
    check_eq("lw_sz11_data", rd, 32'hDEADBEEF);

    // byte / half store as RMW
    xfer(0, 1, 2'b10, 0, 32'h20, 32'h11223344, rd, lat, e);
    r0 = ren_cnt; w0 = wen_cnt;
    xfer(0, 1, 2'b00, 0, 32'h20, 32'hFFFFFFAA, rd, lat, e);
    check_eq("sb_lat", lat, 3);
    check_eq("sb_mem", mword(8'h20), 32'h112233AA);
    check_eq("sb_ren_cycles", ren_cnt - r0, 1);
    check_eq("sb_wen_cycles", wen_cnt - w0, 1);
    xfer(0, 1, 2'b01, 0, 32'h20, 32'h12345566, rd, lat, e);
    check_eq("sh_lat", lat, 3);
    check_eq("sh_mem", mword(8'h20), 32'h11225566);

    // sign / zero extension
    xfer(0, 1, 2'b10, 0, 32'h30, 32'h00000080, rd, lat, e);
    xfer(0, 1, 2'b10, 0, 32'h34, 32'h00008001, rd, lat, e);
    xfer(0, 0, 2'b00, 0, 32'h30, 32'h0, rd, lat, e);
    check_eq("lb", rd, 32'hFFFFFF80);
    xfer(0, 0, 2'b00, 1, 32'h30, 32'h0, rd, lat, e);
    check_eq("lbu", rd, 32'h00000080);
    xfer(0, 0, 2'b01, 0, 32'h34, 32'h0, rd, lat, e);
    check_eq("lh", rd, 32'hFFFF8001);
    xfer(0, 0, 2'b01, 1, 32'h34, 32'h0, rd, lat, e);
    check_eq("lhu", rd, 32'h00008001);
    repeat (3) @(negedge clk);
    check_eq("a_rd_hold", a_rd, 32'h00008001);

    // misaligned word load at 0x22 (bytes 22 11 77 88)
    xfer(0, 1, 2'b10, 0, 32'h24, 32'h00008877, rd, lat, e);
    r0 = ren_cnt; w0 = wen_cnt; k0 = err_cnt;
    xfer(0, 0, 2'b10, 0, 32'h22, 32'h0, rd, lat, e);
`ifdef DMEM_ALIGN_CHECK_EN
    check_eq("mis_lat", lat, 1);
    check_eq("mis_err", {31'd0, e}, 32'd1);
    check_eq("mis_rd_kept", rd, 32'h00008001);
    check_eq("mis_no_mem", (ren_cnt - r0) + (wen_cnt - w0), 0);
`else
    check_eq("mis_lat", lat, 2);
    check_eq("mis_err", {31'd0, e}, 32'd0);
    check_eq("mis_rd", rd, 32'h88771122);
    check_eq("mis_err_cnt", err_cnt - k0, 0);
`endif

    // arbitration: both requesting continuously from reset
    @(negedge clk);
    rst = 1'b1;
    a_we = 0; a_size = 2'b10; a_uns = 0; a_addr = 32'h10; a_req = 1'b1;
    b_we = 0; b_size = 2'b10; b_uns = 0; b_addr = 32'h30; b_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    k0 = both_cnt;
    ord = '0; nack = 0; ard0 = '0; ard1 = '0; brd0 = '0; brd1 = '0;
    r0 = aack_cnt; w0 = back_cnt;
    for (int i = 0; i < 40 && nack < 4; i++) begin
      @(negedge clk);
      if (a_ack && b_ack) check_eq("arb_dual_ack", 32'd1, 32'd0);
      if (a_ack || b_ack) begin
        ord[nack] = b_ack;
        if (a_ack) begin if (nack < 2) ard0 = a_rd; else ard1 = a_rd; end
        if (b_ack) begin if (nack < 2) brd0 = b_rd; else brd1 = b_rd; end
        nack++;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    check_eq("arb_acks", nack, 4);
    check_eq("arb_order", {28'd0, ord}, 32'b1010);
    check_eq("arb_a_cnt", aack_cnt - r0, 2);
    check_eq("arb_b_cnt", back_cnt - w0, 2);
    check_eq("arb_a_rd0", ard0, 32'hDEADBEEF);
    check_eq("arb_a_rd1", ard1, 32'hDEADBEEF);
    check_eq("arb_b_rd0", brd0, 32'h00000080);
    check_eq("arb_b_rd1", brd1, 32'h00000080);

    // reset during RMW_RD
    xfer(0, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, rd, lat, e);
    w0 = wen_cnt; r0 = aack_cnt;
    a_we = 1; a_size = 2'b00; a_uns = 0; a_addr = 32'h40; a_wd = 32'h00000011; a_req = 1'b1;
    @(negedge clk);
    check_eq("rmw_rd_ren", {31'd0, mem_ren}, 32'd1);
    rst = 1'b1;
    a_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("post_rst_outs", {28'd0, a_ack, b_ack, mem_wen, mem_ren}, 32'd0);
    check_eq("post_rst_addr", mem_addr, 32'd0);
    repeat (4) @(negedge clk);
    check_eq("abort_no_wen", wen_cnt - w0, 0);
    check_eq("abort_no_ack", aack_cnt - r0, 0);
    check_eq("abort_mem", mword(8'h40), 32'hCAFEF00D);
    xfer(0, 0, 2'b10, 0, 32'h40, 32'h0, rd, lat, e);
    check_eq("after_abort_lw", rd, 32'hCAFEF00D);

    check_eq("en_exclusive", both_cnt - k0 + both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
